// File: rtl/spi_reg_pkg.sv
// Shared constants and state encoding for the SPI register master and the
// register-file slave that sits on the other end of the same four pins.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_t;

  localparam int   SPI_FRAME_BITS = 16;
  localparam int   SPI_RW_BIT     = 15;
  localparam logic SPI_READ       = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI master.
// div_cnt runs 0..CLK_DIV-1 while enabled and pulses tick on the last count;
// it is held at zero whenever the master is idle so every transaction starts
// from a clean phase.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  logic [7:0] div_cnt;

  assign tick = en && (div_cnt == 8'(CLK_DIV - 1));

  // Free-running half-period counter, cleared when disabled or on wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= 8'd0;
    end else if (!en || tick) begin
      div_cnt <= 8'd0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 master issuing 16-bit {rw, addr[6:0], data[7:0]} frames to the
// register-file slave. One command is accepted in IDLE; the frame runs
// SETUP -> SHIFT (16 SCLK periods) -> HOLD -> GAP and a response pulse is
// issued in the first GAP cycle.
// Optional build macro: SPI_MISO_SYNC_EN -- passes spi_miso through a 2-flop
// synchronizer and samples it on the last system cycle of each SCLK high
// phase (needs CLK_DIV >= 3). Latency is identical in both builds.
// CLK_DIV legal range: 2..255 (3..255 with SPI_MISO_SYNC_EN).
module spi_reg_master #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              busy,
  output logic              spi_cs,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  import spi_reg_pkg::*;

  spi_state_t                state;
  spi_state_t                state_nxt;
  logic                      tick;
  logic                      div_en;
  logic                      accept;
  logic                      rise_edge;
  logic                      fall_edge;
  logic                      last_fall;
  logic                      sclk_q;
  logic                      is_read;
  logic [SPI_FRAME_BITS-1:0] shift_reg;
  logic [4:0]                bit_cnt;
  logic [7:0]                rx;
  logic                      rx_sample;
  logic                      rx_bit;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .tick  (tick)
  );

  assign accept    = cmd_valid && cmd_ready;
  assign rise_edge = (state == SHIFT) && tick && !sclk_q;
  assign fall_edge = (state == SHIFT) && tick && sclk_q;
  assign last_fall = fall_edge && (bit_cnt == 5'(SPI_FRAME_BITS - 1));
  assign spi_clk   = sclk_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: each non-idle phase advances on a divider tick
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = SETUP;
      SETUP:   if (tick)      state_nxt = SHIFT;
      SHIFT:   if (last_fall) state_nxt = HOLD;
      HOLD:    if (tick)      state_nxt = GAP;
      GAP:     if (tick)      state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; mosi only carries data while bits are live
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    spi_cs    = 1'b0;
    spi_mosi  = 1'b0;
    div_en    = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        spi_cs    = 1'b1;
        div_en    = 1'b0;
      end
      SETUP, SHIFT: spi_mosi = shift_reg[SPI_RW_BIT];
      GAP:          spi_cs   = 1'b1;
      default: ;
    endcase
  end

  // SCLK toggles on every half-period tick while shifting, low otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
    end else if (state != SHIFT) begin
      sclk_q <= 1'b0;
    end else if (tick) begin
      sclk_q <= ~sclk_q;
    end
  end

  // Command latch, then MSB-first shift and bit count on each falling edge
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_reg <= {cmd_rw, cmd_addr, cmd_wdata};
      is_read   <= (cmd_rw == SPI_READ);
      bit_cnt   <= 5'd0;
    end else if (fall_edge) begin
      shift_reg <= {shift_reg[SPI_FRAME_BITS-2:0], 1'b0};
      bit_cnt   <= bit_cnt + 5'd1;
    end
  end

`ifdef SPI_MISO_SYNC_EN
  logic miso_s1;
  logic miso_s2;

  // Two-flop synchronizer; sampled at the end of the SCLK high phase
  always_ff @(posedge clk) begin
    miso_s1 <= spi_miso;
    miso_s2 <= miso_s1;
  end

  assign rx_sample = fall_edge;
  assign rx_bit    = miso_s2;
`else
  assign rx_sample = rise_edge;
  assign rx_bit    = spi_miso;
`endif

  // Receive shifter; command-byte bits fall off the top, data byte remains
  always_ff @(posedge clk) begin
    if (rx_sample) begin
      rx <= {rx[6:0], rx_bit};
    end
  end

  // Response pulse in the first GAP cycle; rdata holds until the next one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      rsp_valid <= (state == HOLD) && tick;
      if ((state == HOLD) && tick) begin
        rsp_rdata <= is_read ? rx : 8'h00;
      end
    end
  end

endmodule
